cdc_latch_tx: RTL

Source-side controller that feeds the multi-bit `d_latch` holding register in the CDC synchronizer path. It accepts words over a valid/ready interface and drives the latch data bus and enable pulse with guaranteed setup, open and hold windows. It then signals the destination domain with a toggle request and blocks until the synchronized toggle acknowledge returns. One word is in flight at a time (bundled-data, 4-phase-free toggle protocol).

---
 rtl/cdc_pkg.sv | 31 +++
 rtl/cdc_latch_tx_if.sv | 27 ++
 rtl/bit_sync.sv | 26 ++
 rtl/cdc_latch_tx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and defaults for the CDC latch transmitter.
// The ERROR state exists only when CDC_TX_TIMEOUT_EN is defined.
package cdc_pkg;

  localparam int DEF_N           = 8;
  localparam int DEF_SETUP_CYC   = 1;
  localparam int DEF_OPEN_CYC    = 2;
  localparam int DEF_HOLD_CYC    = 1;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD,
`ifdef CDC_TX_TIMEOUT_EN
    WAIT_ACK,
    ERROR
`else
    WAIT_ACK
`endif
  } cdc_tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdc_latch_tx_if.sv
// Source-side bus of the CDC latch transmitter: word handshake, latch drive,
// toggle request/acknowledge and status.
interface cdc_latch_tx_if import cdc_pkg::*; #(
  parameter int N = DEF_N
) ();

  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] latch_data;
  logic         latch_en;
  logic         req_tgl;
  logic         ack_tgl;
  logic         busy;
  logic         err;

  modport master (
    input  in_data, in_valid, ack_tgl,
    output in_ready, latch_data, latch_en, req_tgl, busy, err
  );

  modport slave (
    output in_data, in_valid, ack_tgl,
    input  in_ready, latch_data, latch_en, req_tgl, busy, err
  );

endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single level/toggle signal, cleared by reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: synchronizer flops are reset so a stale toggle cannot look like an acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_latch_tx.sv
// Drives a d_latch holding register with timed setup/open/hold windows, then
// hands the word to the destination via a toggle req/ack. Option: CDC_TX_TIMEOUT_EN.
module cdc_latch_tx import cdc_pkg::*; #(
  parameter int N           = DEF_N,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int OPEN_CYC    = DEF_OPEN_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic            clk,
  input  logic            rst_n,
  cdc_latch_tx_if.master  bus
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, OPEN_CYC, HOLD_CYC)) + 1;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  if (SETUP_CYC < 1)   begin : g_bad_setup $error("SETUP_CYC must be >= 1");   end
  if (OPEN_CYC < 1)    begin : g_bad_open  $error("OPEN_CYC must be >= 1");    end
  if (HOLD_CYC < 1)    begin : g_bad_hold  $error("HOLD_CYC must be >= 1");    end
  if (SYNC_STAGES < 2) begin : g_bad_sync  $error("SYNC_STAGES must be >= 2"); end
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo   $error("TIMEOUT_CYC must be >= 1"); end

  cdc_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     latch_data_q, latch_data_d;
  logic             latch_en_q, latch_en_d;
  logic             req_q, req_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             ack_sync;

  bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.ack_tgl),
    .q     (ack_sync)
  );

`ifdef CDC_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // NOTE: every *_d gets its hold value first so no path leaves a latch behind.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    latch_data_d = latch_data_q;
    req_d        = req_q;
`ifdef CDC_TX_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = err_q;
`endif

    case (state_q)
      IDLE: begin
        // in_ready_q is low on the first edge after reset, so nothing is taken then.
        if (bus.in_valid && in_ready_q) begin
          latch_data_d = bus.in_data;
          state_d      = SETUP;
          cnt_d        = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = OPEN;
          cnt_d   = OPEN_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OPEN: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
          req_d   = ~req_q;
`ifdef CDC_TX_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (ack_sync == req_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`ifdef CDC_TX_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
`ifdef CDC_TX_TIMEOUT_EN
      ERROR: state_d = ERROR;
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they are glitch-free flops.
    latch_en_d = (state_d == OPEN);
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // NOTE: state updates use <= so every flop samples the pre-edge values together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      latch_data_q <= '0;
      latch_en_q   <= 1'b0;
      req_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      latch_data_q <= latch_data_d;
      latch_en_q   <= latch_en_d;
      req_q        <= req_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
`ifdef CDC_TX_TIMEOUT_EN
      tmo_q        <= tmo_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.latch_data = latch_data_q;
  assign bus.latch_en   = latch_en_q;
  assign bus.req_tgl    = req_q;
  assign bus.busy       = busy_q;
`ifdef CDC_TX_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule
